// File: rtl/rsa_mmm_unit.sv
// ---------------------------------------------------------------------------
// rsa_mmm_unit
//
// Purpose:
//   Bit-serial Montgomery modular multiplier computing
//     r = a * b * 2^-WIDTH mod m
//   The RSA exponentiation controller sequences it: one ld_a strobe, then
//   WIDTH step cycles (no strobe), then one ld_r strobe. This block counts
//   the steps itself. It raises a sticky err flag when the controller breaks
//   that sequence, by capturing too early or by stepping past the end.
//
// Ports:
//   clk        in   1      clock, all flops on posedge
//   rst        in   1      asynchronous active-high reset
//   ena        in   1      global enable; 0 = every register holds
//   clear_mmm  in   1      active-low synchronous clear of acc/cnt/state/err
//   ld_a       in   1      load multiplier, zero accumulator, start iteration
//   ld_r       in   1      capture the final reduced result into r
//   a          in   WIDTH  multiplier, sampled only on ld_a
//   b          in   WIDTH  multiplicand, stable from ld_a through ld_r
//   m          in   WIDTH  odd modulus, stable from ld_a through ld_r
//   r          out  WIDTH  result register
//   r_valid    out  1      one-cycle pulse after a successful capture
//   busy       out  1      high while iterating (state RUN)
//   err        out  1      sticky sequencing-error flag
// ---------------------------------------------------------------------------
module rsa_mmm_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear_mmm,
  input  logic             ld_a,
  input  logic             ld_r,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] r,
  output logic             r_valid,
  output logic             busy,
  output logic             err
);

  // The accumulator stays below 2m after every step. A step adds at most
  // b + m < 2m to it, so the pre-shift sum is below 4m < 2^(WIDTH+2).
  localparam int AW    = WIDTH + 2;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg,   state_next;
  logic [AW-1:0]    acc_reg,     acc_next;
  logic [WIDTH-1:0] a_sh_reg,    a_sh_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic [WIDTH-1:0] r_reg,       r_next;
  logic             r_valid_reg, r_valid_next;
  logic             err_reg,     err_next;

  // Datapath for one Montgomery step and for the final reduction.
  logic [AW-1:0]    b_ext;
  logic [AW-1:0]    m_ext;
  logic             q;
  logic [AW-1:0]    addend_b;
  logic [AW-1:0]    addend_m;
  logic [AW-1:0]    acc_sum;
  logic [WIDTH-1:0] r_final;

  assign b_ext = {2'b00, b};
  assign m_ext = {2'b00, m};

  // q is chosen so that the sum is even and the shift right is exact.
  assign q        = acc_reg[0] ^ (a_sh_reg[0] & b[0]);
  assign addend_b = a_sh_reg[0] ? b_ext : '0;
  assign addend_m = q ? m_ext : '0;
  assign acc_sum  = acc_reg + addend_b + addend_m;

  // Because acc < 2m, one conditional subtraction is enough. Only the low
  // WIDTH bits of the difference are kept, so a WIDTH-bit subtract is exact.
  assign r_final = (acc_reg >= m_ext) ? (acc_reg[WIDTH-1:0] - m)
                                      : acc_reg[WIDTH-1:0];

  // State register. The enable gates every flop, r_valid included, so a
  // pulse that is pending while ena is low stays visible until ena returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      acc_reg     <= '0;
      a_sh_reg    <= '0;
      cnt_reg     <= '0;
      r_reg       <= '0;
      r_valid_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else if (ena) begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      a_sh_reg    <= a_sh_next;
      cnt_reg     <= cnt_next;
      r_reg       <= r_next;
      r_valid_reg <= r_valid_next;
      err_reg     <= err_next;
    end
  end

  // Next-state logic. The strobes are decoded in strict priority:
  // clear, load, capture, then free-running step/overrun by state.
  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    a_sh_next    = a_sh_reg;
    cnt_next     = cnt_reg;
    r_next       = r_reg;
    r_valid_next = 1'b0;
    err_next     = err_reg;

    if (!clear_mmm) begin
      acc_next   = '0;
      cnt_next   = CNT_ZERO;
      state_next = ST_IDLE;
      err_next   = 1'b0;
    end else if (ld_a) begin
      // A load during RUN or DONE is a clean restart. Any partial result
      // is discarded.
      a_sh_next  = a;
      acc_next   = '0;
      cnt_next   = CNT_ZERO;
      err_next   = 1'b0;
      state_next = ST_RUN;
    end else if (ld_r) begin
      if (state_reg == ST_DONE) begin
        r_next       = r_final;
        r_valid_next = 1'b1;
        state_next   = ST_IDLE;
      end else begin
        // A capture before the iteration has finished is a controller
        // fault. r keeps its old value.
        err_next = 1'b1;
      end
    end else begin
      unique case (state_reg)
        ST_RUN: begin
          acc_next  = acc_sum >> 1;
          a_sh_next = a_sh_reg >> 1;
          cnt_next  = cnt_reg + CNT_ONE;
          if (cnt_reg == CNT_LAST) begin
            state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          // An extra step after the last one. Flag it but leave acc
          // untouched so that a later capture still gives the right answer.
          err_next = 1'b1;
        end
        default: begin
          // Idle: hold.
        end
      endcase
    end
  end

  assign busy    = (state_reg == ST_RUN);
  assign r       = r_reg;
  assign r_valid = r_valid_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_rsa_mmm_unit.sv
// ---------------------------------------------------------------------------
// tb_rsa_mmm_unit
//
// Directed testbench for rsa_mmm_unit with WIDTH=8. Each expected result is
// worked out by hand as a*b*R^-1 mod m with R = 256:
//   m=13 : 256 mod 13 = 9,  9^-1 mod 13 = 3
//   m=11 : 256 mod 11 = 3,  3^-1 mod 11 = 4
//   m=255: 256 mod 255 = 1, 1^-1 = 1
// ---------------------------------------------------------------------------
module tb_rsa_mmm_unit;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             ena;
  logic             clear_mmm;
  logic             ld_a;
  logic             ld_r;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] r;
  logic             r_valid;
  logic             busy;
  logic             err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rsa_mmm_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .clear_mmm (clear_mmm),
    .ld_a      (ld_a),
    .ld_r      (ld_r),
    .a         (a),
    .b         (b),
    .m         (m),
    .r         (r),
    .r_valid   (r_valid),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock. Inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] mv);
    a    = av;
    b    = bv;
    m    = mv;
    ld_a = 1'b1;
    tick();
    ld_a = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) tick();
  endtask

  task automatic capture();
    ld_r = 1'b1;
    tick();
    ld_r = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (r !== 8'd0) $display("FAIL reset_r: got %0d want 0", r); else pass_cnt++;
    total_cnt++;
    if (r_valid !== 1'b0) $display("FAIL reset_r_valid: got %b want 0", r_valid); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
    rst = 1'b0;
    tick();
    $display("reset: r=%0d r_valid=%b busy=%b err=%b", r, r_valid, busy, err);
  endtask

  task automatic test_basic();
    start_op(8'd5, 8'd7, 8'd13);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy_run: got %b want 1", busy); else pass_cnt++;
    steps(8);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL basic_busy_done: got %b want 0", busy); else pass_cnt++;
    capture();
    $display("op a=5 b=7 m=13: r=%0d r_valid=%b err=%b", r, r_valid, err);
    total_cnt++;
    if (r !== 8'd1) $display("FAIL basic_r: got %0d want 1", r); else pass_cnt++;
    total_cnt++;
    if (r_valid !== 1'b1) $display("FAIL basic_r_valid: got %b want 1", r_valid); else pass_cnt++;
    total_cnt++;
    if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else pass_cnt++;
    tick();
    total_cnt++;
    if (r_valid !== 1'b0) $display("FAIL basic_r_valid_pulse: got %b want 0", r_valid); else pass_cnt++;
  endtask

  task automatic test_vectors();
    logic [WIDTH-1:0] va [5];
    logic [WIDTH-1:0] vb [5];
    logic [WIDTH-1:0] vm [5];
    logic [WIDTH-1:0] vr [5];
    va = '{8'd1,  8'd0,  8'd12, 8'd7,  8'd254};
    vb = '{8'd1,  8'd9,  8'd12, 8'd9,  8'd254};
    vm = '{8'd13, 8'd13, 8'd13, 8'd11, 8'd255};
    vr = '{8'd3,  8'd0,  8'd3,  8'd10, 8'd1};
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], vm[i]);
      steps(8);
      capture();
      $display("op a=%0d b=%0d m=%0d: r=%0d r_valid=%b", va[i], vb[i], vm[i], r, r_valid);
      total_cnt++;
      if (r !== vr[i] || r_valid !== 1'b1)
        $display("FAIL vector_%0d: got r=%0d r_valid=%b want r=%0d r_valid=1",
                 i, r, r_valid, vr[i]);
      else pass_cnt++;
    end
    tick();
  endtask

  // The previous r is 1 (from m=255). This operation's result is 3.
  task automatic test_early_ld_r();
    start_op(8'd1, 8'd1, 8'd13);
    steps(5);
    capture();
    $display("early ld_r: r=%0d err=%b busy=%b r_valid=%b", r, err, busy, r_valid);
    total_cnt++;
    if (err !== 1'b1) $display("FAIL early_err: got %b want 1", err); else pass_cnt++;
    total_cnt++;
    if (r !== 8'd1) $display("FAIL early_r_hold: got %0d want 1", r); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL early_busy: got %b want 1", busy); else pass_cnt++;
    total_cnt++;
    if (r_valid !== 1'b0) $display("FAIL early_r_valid: got %b want 0", r_valid); else pass_cnt++;
    steps(3);
    capture();
    $display("late ld_r: r=%0d err=%b r_valid=%b", r, err, r_valid);
    total_cnt++;
    if (r !== 8'd3) $display("FAIL early_final_r: got %0d want 3", r); else pass_cnt++;
    total_cnt++;
    if (err !== 1'b1) $display("FAIL early_err_sticky: got %b want 1", err); else pass_cnt++;
    tick();
  endtask

  task automatic test_overrun();
    start_op(8'd7, 8'd9, 8'd11);
    total_cnt++;
    if (err !== 1'b0) $display("FAIL overrun_ld_a_clears_err: got %b want 0", err); else pass_cnt++;
    steps(9);
    total_cnt++;
    if (err !== 1'b1) $display("FAIL overrun_err: got %b want 1", err); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL overrun_busy: got %b want 0", busy); else pass_cnt++;
    capture();
    $display("overrun op a=7 b=9 m=11: r=%0d err=%b r_valid=%b", r, err, r_valid);
    total_cnt++;
    if (r !== 8'd10) $display("FAIL overrun_acc_kept: got r=%0d want 10", r); else pass_cnt++;
    start_op(8'd5, 8'd7, 8'd13);
    total_cnt++;
    if (err !== 1'b0) $display("FAIL overrun_err_cleared: got %b want 0", err); else pass_cnt++;
    steps(8);
    capture();
    tick();
  endtask

  // The previous r is 1. Run a=12,b=12,m=13 (result 3) with a 4-cycle freeze.
  task automatic test_ena_hold();
    start_op(8'd12, 8'd12, 8'd13);
    steps(3);
    ena = 1'b0;
    steps(4);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL ena_busy_frozen: got %b want 1", busy); else pass_cnt++;
    ena = 1'b1;
    // With the freeze honoured, 4 more steps leave the unit still running.
    steps(4);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL ena_cnt_frozen: got busy=%b want 1", busy); else pass_cnt++;
    steps(1);
    capture();
    $display("ena-hold op a=12 b=12 m=13: r=%0d r_valid=%b err=%b", r, r_valid, err);
    total_cnt++;
    if (r !== 8'd3 || r_valid !== 1'b1)
      $display("FAIL ena_result: got r=%0d r_valid=%b want r=3 r_valid=1", r, r_valid);
    else pass_cnt++;
    ena = 1'b0;
    tick();
    total_cnt++;
    if (r_valid !== 1'b1) $display("FAIL ena_r_valid_hold: got %b want 1", r_valid); else pass_cnt++;
    ena = 1'b1;
    tick();
    total_cnt++;
    if (r_valid !== 1'b0) $display("FAIL ena_r_valid_drop: got %b want 0", r_valid); else pass_cnt++;
  endtask

  // The previous r is 3.
  task automatic test_clear();
    start_op(8'd5, 8'd7, 8'd13);
    steps(4);
    clear_mmm = 1'b0;
    tick();
    clear_mmm = 1'b1;
    $display("clear mid-run: r=%0d busy=%b err=%b r_valid=%b", r, busy, err, r_valid);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL clear_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++;
    if (r !== 8'd3) $display("FAIL clear_r_hold: got %0d want 3", r); else pass_cnt++;
    capture();
    total_cnt++;
    if (err !== 1'b1 || r !== 8'd3)
      $display("FAIL clear_idle_ld_r: got err=%b r=%0d want err=1 r=3", err, r);
    else pass_cnt++;
    clear_mmm = 1'b0;
    tick();
    clear_mmm = 1'b1;
    total_cnt++;
    if (err !== 1'b0) $display("FAIL clear_err: got %b want 0", err); else pass_cnt++;
  endtask

  // The previous r is 3.
  task automatic test_simultaneous();
    start_op(8'd5, 8'd7, 8'd13);
    steps(8);
    a    = 8'd1;
    b    = 8'd1;
    ld_a = 1'b1;
    ld_r = 1'b1;
    tick();
    ld_a = 1'b0;
    ld_r = 1'b0;
    $display("ld_a+ld_r: r=%0d r_valid=%b busy=%b err=%b", r, r_valid, busy, err);
    total_cnt++;
    if (r !== 8'd3 || r_valid !== 1'b0 || busy !== 1'b1 || err !== 1'b0)
      $display("FAIL simul_restart: got r=%0d r_valid=%b busy=%b err=%b want r=3 r_valid=0 busy=1 err=0",
               r, r_valid, busy, err);
    else pass_cnt++;
    steps(8);
    capture();
    total_cnt++;
    if (r !== 8'd3 || r_valid !== 1'b1)
      $display("FAIL simul_result: got r=%0d r_valid=%b want r=3 r_valid=1", r, r_valid);
    else pass_cnt++;
    // Back-to-back operation straight after the capture cycle.
    start_op(8'd5, 8'd7, 8'd13);
    total_cnt++;
    if (r_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_start: got r_valid=%b busy=%b want 0 1", r_valid, busy);
    else pass_cnt++;
    steps(8);
    capture();
    total_cnt++;
    if (r !== 8'd1) $display("FAIL b2b_r: got %0d want 1", r); else pass_cnt++;
    tick();
  endtask

  task automatic test_async_rst();
    start_op(8'd7, 8'd9, 8'd11);
    steps(3);
    capture();
    // The early capture leaves err=1 and busy=1 with r=1 still held.
    rst = 1'b1;
    #1;
    $display("async rst: r=%0d r_valid=%b busy=%b err=%b", r, r_valid, busy, err);
    total_cnt++;
    if (r !== 8'd0 || r_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL async_rst: got r=%0d r_valid=%b busy=%b err=%b want all 0",
               r, r_valid, busy, err);
    else pass_cnt++;
    #2;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    ena       = 1'b1;
    clear_mmm = 1'b1;
    ld_a      = 1'b0;
    ld_r      = 1'b0;
    a         = '0;
    b         = '0;
    m         = 8'd13;

    test_reset();
    test_basic();
    test_vectors();
    test_early_ld_r();
    test_overrun();
    test_ena_hold();
    test_clear();
    test_simultaneous();
    test_async_rst();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
